// File: rtl/core_input_feeder.sv
// core_input_feeder
//
// Shared-input dispatcher for the multicore Taylor-network array. Samples
// arrive from an upstream source into a small FIFO. Each core raises a
// non-zero request code; one core per cycle is granted in round-robin order
// and receives the FIFO head on the shared io_in bus.
//
// Ports
//   clk, rst_n   single clock (posedge), asynchronous active-low reset
//   s_data       upstream sample (signed)
//   s_valid      upstream sample valid
//   s_ready      FIFO has a free slot (from registered occupancy)
//   req_in       flattened per-core request codes, core i at [i*REQ_W +: REQ_W]
//   io_in        shared sample bus, valid while any io_grant bit is high
//   io_grant     one-hot, one-cycle grant pulse
//   io_code      request code of the granted core
//   stall_cnt    saturating count of cycles with requests pending on an empty FIFO
//   fifo_level   current FIFO occupancy
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | no grant issued at the last edge, nothing locked
// ST_GRANT | grant issued at the last edge, granted core is locked

module core_input_feeder #(
  parameter int N_CORES    = 21,
  parameter int DATA_W     = 19,
  parameter int REQ_W      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DATA_W-1:0]      s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [N_CORES*REQ_W-1:0]      req_in,
  output logic signed [DATA_W-1:0]      io_in,
  output logic [N_CORES-1:0]            io_grant,
  output logic [REQ_W-1:0]              io_code,
  output logic [15:0]                   stall_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_CORES - 1);
  localparam logic [N_CORES-1:0] ONE_HOT0 = N_CORES'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                    state_q, state_d;

  logic signed [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic signed [DATA_W-1:0]  io_in_q, io_in_d;
  logic [N_CORES-1:0]        grant_q, grant_d;
  logic [REQ_W-1:0]          code_q, code_d;
  logic [15:0]               stall_q, stall_d;

  logic [REQ_W-1:0]          req_arr [N_CORES];
  logic [N_CORES-1:0]        lock_mask;
  logic [N_CORES-1:0]        pend;
  logic                      any_pend;
  logic                      empty;
  logic                      push;
  logic                      fire;

  logic                      win_found;
  logic [IDX_W-1:0]          win_idx;
  int                        scan_sum;
  logic [IDX_W-1:0]          scan_idx;

  // The lock mask is exactly the grant issued at the previous edge, so the
  // registered grant vector doubles as the lock register; it only applies
  // while the FSM sits in ST_GRANT.
  assign lock_mask = (state_q == ST_GRANT) ? grant_q : '0;

  for (genvar g = 0; g < N_CORES; g++) begin : g_req
    assign req_arr[g] = req_in[g*REQ_W +: REQ_W];
    assign pend[g]    = (req_arr[g] != '0) && !lock_mask[g];
  end

  assign any_pend = |pend;
  assign empty    = (cnt_q == '0);
  assign s_ready  = (cnt_q < DEPTH_C);
  assign push     = s_valid && s_ready;
  assign fire     = win_found && !empty;

  // Round-robin scan: start one past the last winner and wrap modulo N_CORES.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = 0;
    scan_idx  = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      scan_sum = int'(rr_ptr_q) + k;
      if (scan_sum >= N_CORES) begin
        scan_sum = scan_sum - N_CORES;
      end
      scan_idx = IDX_W'(scan_sum);
      if (!win_found && pend[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d  = fire ? ST_GRANT : ST_IDLE;
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = fire ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    cnt_d = cnt_q;
    if (push && !fire) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!push && fire) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    rr_ptr_d = fire ? win_idx : rr_ptr_q;
    io_in_d  = fire ? mem_q[rd_ptr_q] : io_in_q;
    grant_d  = fire ? (ONE_HOT0 << win_idx) : '0;
    code_d   = fire ? req_arr[win_idx] : code_q;

    stall_d = stall_q;
    if (any_pend && empty && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Sample storage carries no reset; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= LAST_IDX;
      io_in_q  <= '0;
      grant_q  <= '0;
      code_q   <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      io_in_q  <= io_in_d;
      grant_q  <= grant_d;
      code_q   <= code_d;
      stall_q  <= stall_d;
    end
  end

  assign io_in      = io_in_q;
  assign io_grant   = grant_q;
  assign io_code    = code_q;
  assign stall_cnt  = stall_q;
  assign fifo_level = cnt_q;

endmodule
